id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It captures decoded control, register numbers, operands, immediate and PC+4 from the decode stage.
- It presents these as the ID_EX_* signals used by the EX-stage ALU muxes and the forwarding unit.
- It contains load-use hazard detection. On a load-use hazard it inserts a bubble and requests an upstream hold of the PC and IF/ID.
- It also handles external stall (freeze) and flush (branch squash).

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- REG_ADDR_W, 5, register-number width.
- ALUOP_W, 2, ALU operation code width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  external freeze; the register holds its contents.
- flush  in  1  squash; the register loads a bubble.
- id_valid  in  1  decode stage holds a real instruction.
- id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst  in  1 each  decoded control.
- id_aluOp  in  ALUOP_W  ALU op.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register numbers.
- id_readData1, id_readData2, id_imm, id_pc4  in  DATA_W  operands, sign-extended immediate, PC+4.
- ID_EX_valid  out  1  registered valid.
- ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg, ID_EX_aluSrc, ID_EX_regDst  out  1 each  registered control.
- ID_EX_aluOp  out  ALUOP_W.
- ID_EX_rs, ID_EX_rt, ID_EX_rd  out  REG_ADDR_W.
- ID_EX_readData1, ID_EX_readData2, ID_EX_imm, ID_EX_pc4  out  DATA_W.
- ld_use_hold  out  1  combinational; upstream must hold the PC and IF/ID this cycle.
- bubble_count, flush_count  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): every ID_EX_* output is 0, and the counters are 0. rst_n has priority over all other inputs.
- Bubble definition: valid, regWrite, memRead and memWrite are 0. The remaining fields are don't-care, and the implementation drives them to 0.
- ld_use_hold:
  - = ID_EX_valid & ID_EX_memRead & id_valid & (ID_EX_rt != 0) & ((ID_EX_rt == id_rs) | (ID_EX_rt == id_rt)).
  - It is forced to 0 while flush=1, and it is purely combinational.
- Priority at each rising edge, highest first:
  1. rst_n=0: reset.
  2. flush=1: load a bubble. Flush wins over stall, because a squashed instruction must not persist.
  3. stall=1: hold all registers unchanged.
  4. ld_use_hold=1: load a bubble. The stalled instruction stays in IF/ID and is re-presented next cycle.
  5. Otherwise: load all id_* fields, and ID_EX_valid <= id_valid.
- Latency: 1 cycle from id_* to ID_EX_*.
- Load-use penalty: exactly 1 bubble. In the next cycle the load has moved to EX/MEM, so ID_EX_memRead is from the bubble and ld_use_hold deasserts. The dependent instruction then loads, and MEM/WB forwarding covers it.
- When id_valid=0 on a normal load, the control bits still load, but ID_EX_regWrite, ID_EX_memRead and ID_EX_memWrite are gated to 0, so an invalid slot never writes or triggers a hazard.
- Reset mid-operation: contents are discarded with no drain. ld_use_hold is 0 in the cycle after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- With the macro:
  - bubble_count increments on every edge where a bubble is inserted by ld_use_hold (not when stall is high).
  - flush_count increments on every edge with flush=1 and rst_n=1.
  - Both counters are 32-bit and saturate at 32'hFFFF_FFFF, and both hold during stall except that flush_count still counts.
- Without the macro: no counter flops are built, and both outputs are tied to 32'h0.

Decomposition:
- Shared pipeline package holds:
  - typedef for the EX control bundle (regDst, aluSrc, aluOp);
  - typedef for the MEM control bundle (memRead, memWrite);
  - typedef for the WB control bundle (regWrite, memToReg);
  - constant REG_ZERO = 5'd0;
  - the ALUOP encodings.
- One natural sub-module is load_use_detect, which holds the combinational ld_use_hold equation. It is reusable by the IF/ID register and PC hold logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random id_* inputs -> all ID_EX_* outputs = 0, and ld_use_hold = 0.
- Normal flow: id_rs=3, id_rt=4, id_rd=5, id_readData1=32'h1234, id_regWrite=1, id_valid=1 -> the next cycle shows ID_EX_rs=3, ID_EX_rt=4, ID_EX_rd=5, ID_EX_readData1=32'h1234, ID_EX_regWrite=1.
- Load-use: lw with rt=8 is in ID/EX (memRead=1); the decode stage presents add with rs=8 -> ld_use_hold=1, then a bubble (ID_EX_valid=0, regWrite=0), then the add loads with ID_EX_rs=8, ld_use_hold=0, and bubble_count=1.
- $zero exemption: lw with rt=0 in ID/EX, decode rs=0 -> ld_use_hold=0, and no bubble is inserted.
- Stall vs flush: ID/EX holds rd=7 and stall=1 for 3 cycles -> ID_EX_rd=7 is held. Then stall=1 and flush=1 on the same edge -> bubble loaded, ID_EX_valid=0, and flush_count=1.
- Flush suppresses the hazard: lw rt=9 in ID/EX, decode rs=9, flush=1 -> ld_use_hold=0, a bubble is loaded, and bubble_count is unchanged.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions for the ID/EX stage register.
// Holds the default field widths, the ALU op encodings, the $zero register
// number and the EX/MEM/WB control bundles carried down the pipeline.
package id_ex_stage_reg_pkg;

    localparam int unsigned DFLT_DATA_W     = 32;
    localparam int unsigned DFLT_REG_ADDR_W = 5;
    localparam int unsigned DFLT_ALUOP_W    = 2;

    typedef logic [DFLT_ALUOP_W-1:0] aluop_t;

    // ALU op encodings handed to the EX-stage ALU control
    localparam aluop_t ALUOP_ADD   = 2'b00;  // loads/stores: address add
    localparam aluop_t ALUOP_SUB   = 2'b01;  // beq: compare by subtract
    localparam aluop_t ALUOP_FUNCT = 2'b10;  // R-type: decode funct field
    localparam aluop_t ALUOP_IMM   = 2'b11;  // immediate arithmetic/logic

    localparam logic [DFLT_REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic   regDst;
        logic   aluSrc;
        aluop_t aluOp;
    } ex_ctrl_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wb_ctrl_t;

    // Complete control word held in ID/EX
    typedef struct packed {
        logic      valid;
        wb_ctrl_t  wb;
        mem_ctrl_t mem;
        ex_ctrl_t  ex;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-EX bus of the ID/EX stage register.
// id_*       : decoded instruction presented by the decode stage
// ID_EX_*    : registered copy seen by the EX-stage muxes and forwarding unit
// ld_use_hold: combinational hold request for the PC and IF/ID
// bubble_count / flush_count: performance counters (zero unless enabled)
// master = decode side / observer, slave = the stage register.
interface id_ex_stage_reg_if #(
    parameter int unsigned DATA_W     = id_ex_stage_reg_pkg::DFLT_DATA_W,
    parameter int unsigned REG_ADDR_W = id_ex_stage_reg_pkg::DFLT_REG_ADDR_W,
    parameter int unsigned ALUOP_W    = id_ex_stage_reg_pkg::DFLT_ALUOP_W
);

    logic                  id_valid;
    logic                  id_regWrite;
    logic                  id_memRead;
    logic                  id_memWrite;
    logic                  id_memToReg;
    logic                  id_aluSrc;
    logic                  id_regDst;
    logic [ALUOP_W-1:0]    id_aluOp;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [DATA_W-1:0]     id_readData1;
    logic [DATA_W-1:0]     id_readData2;
    logic [DATA_W-1:0]     id_imm;
    logic [DATA_W-1:0]     id_pc4;

    logic                  ID_EX_valid;
    logic                  ID_EX_regWrite;
    logic                  ID_EX_memRead;
    logic                  ID_EX_memWrite;
    logic                  ID_EX_memToReg;
    logic                  ID_EX_aluSrc;
    logic                  ID_EX_regDst;
    logic [ALUOP_W-1:0]    ID_EX_aluOp;
    logic [REG_ADDR_W-1:0] ID_EX_rs;
    logic [REG_ADDR_W-1:0] ID_EX_rt;
    logic [REG_ADDR_W-1:0] ID_EX_rd;
    logic [DATA_W-1:0]     ID_EX_readData1;
    logic [DATA_W-1:0]     ID_EX_readData2;
    logic [DATA_W-1:0]     ID_EX_imm;
    logic [DATA_W-1:0]     ID_EX_pc4;

    logic                  ld_use_hold;
    logic [31:0]           bubble_count;
    logic [31:0]           flush_count;

    modport master (
        output id_valid, id_regWrite, id_memRead, id_memWrite, id_memToReg,
               id_aluSrc, id_regDst, id_aluOp, id_rs, id_rt, id_rd,
               id_readData1, id_readData2, id_imm, id_pc4,
        input  ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite,
               ID_EX_memToReg, ID_EX_aluSrc, ID_EX_regDst, ID_EX_aluOp,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_readData1, ID_EX_readData2,
               ID_EX_imm, ID_EX_pc4, ld_use_hold, bubble_count, flush_count
    );

    modport slave (
        input  id_valid, id_regWrite, id_memRead, id_memWrite, id_memToReg,
               id_aluSrc, id_regDst, id_aluOp, id_rs, id_rt, id_rd,
               id_readData1, id_readData2, id_imm, id_pc4,
        output ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite,
               ID_EX_memToReg, ID_EX_aluSrc, ID_EX_regDst, ID_EX_aluOp,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_readData1, ID_EX_readData2,
               ID_EX_imm, ID_EX_pc4, ld_use_hold, bubble_count, flush_count
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: asks upstream to hold when the load sitting in
// ID/EX writes a register the decoding instruction reads.
// Ports: ex_* = instruction currently in ID/EX, id_* = decoding instruction,
// squash_i = flush in progress (kills the request), ld_use_hold_c = request.
// Reusable by the IF/ID register and PC hold logic.
module id_ex_stage_reg_load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DFLT_REG_ADDR_W
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  squash_i,
    output logic                  ld_use_hold_c
);

    logic rt_nonzero;
    logic rt_match;

    // $zero is never a real dependency
    assign rt_nonzero = (ex_rt_i != REG_ADDR_W'(REG_ZERO));
    assign rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);

    assign ld_use_hold_c = ex_valid_i && ex_mem_read_i && id_valid_i &&
                           rt_nonzero && rt_match && !squash_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core with load-use bubble
// insertion, external freeze (stall) and branch squash (flush).
// Ports: clk, rst_n (synchronous, active low), stall, flush, and the bus
// interface (slave) carrying id_* in, ID_EX_* / ld_use_hold / counters out.
// Optional build macro ID_EX_PERF_CNT_EN adds saturating bubble and flush
// counters; without it both counter outputs are tied to zero.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W     = DFLT_DATA_W,
    parameter int unsigned REG_ADDR_W = DFLT_REG_ADDR_W,
    parameter int unsigned ALUOP_W    = DFLT_ALUOP_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic flush,
    id_ex_stage_reg_if.slave bus
);

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc4;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t id_stage;
    logic   ld_use_hold;

    id_ex_stage_reg_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid_i    (stage_q.ctrl.valid),
        .ex_mem_read_i (stage_q.ctrl.mem.memRead),
        .ex_rt_i       (stage_q.rt),
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .squash_i      (flush),
        .ld_use_hold_c (ld_use_hold)
    );

    // Incoming decode slot; side-effecting controls are gated by id_valid
    always_comb begin
        id_stage                   = '0;
        id_stage.ctrl.valid        = bus.id_valid;
        id_stage.ctrl.wb.regWrite  = bus.id_regWrite & bus.id_valid;
        id_stage.ctrl.wb.memToReg  = bus.id_memToReg;
        id_stage.ctrl.mem.memRead  = bus.id_memRead & bus.id_valid;
        id_stage.ctrl.mem.memWrite = bus.id_memWrite & bus.id_valid;
        id_stage.ctrl.ex.regDst    = bus.id_regDst;
        id_stage.ctrl.ex.aluSrc    = bus.id_aluSrc;
        id_stage.ctrl.ex.aluOp     = bus.id_aluOp;
        id_stage.rs                = bus.id_rs;
        id_stage.rt                = bus.id_rt;
        id_stage.rd                = bus.id_rd;
        id_stage.rd1               = bus.id_readData1;
        id_stage.rd2               = bus.id_readData2;
        id_stage.imm               = bus.id_imm;
        id_stage.pc4               = bus.id_pc4;
    end

    // Next-state: flush beats stall so a squashed slot never persists
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            if (ld_use_hold) begin
                stage_d = '0;
            end else begin
                stage_d = id_stage;
            end
        end
    end

    // Pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.ID_EX_valid     = stage_q.ctrl.valid;
    assign bus.ID_EX_regWrite  = stage_q.ctrl.wb.regWrite;
    assign bus.ID_EX_memToReg  = stage_q.ctrl.wb.memToReg;
    assign bus.ID_EX_memRead   = stage_q.ctrl.mem.memRead;
    assign bus.ID_EX_memWrite  = stage_q.ctrl.mem.memWrite;
    assign bus.ID_EX_regDst    = stage_q.ctrl.ex.regDst;
    assign bus.ID_EX_aluSrc    = stage_q.ctrl.ex.aluSrc;
    assign bus.ID_EX_aluOp     = stage_q.ctrl.ex.aluOp;
    assign bus.ID_EX_rs        = stage_q.rs;
    assign bus.ID_EX_rt        = stage_q.rt;
    assign bus.ID_EX_rd        = stage_q.rd;
    assign bus.ID_EX_readData1 = stage_q.rd1;
    assign bus.ID_EX_readData2 = stage_q.rd2;
    assign bus.ID_EX_imm       = stage_q.imm;
    assign bus.ID_EX_pc4       = stage_q.pc4;
    assign bus.ld_use_hold     = ld_use_hold;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Saturating counters; a stall freezes bubbles but flushes still count
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!flush && !stall && ld_use_hold && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.bubble_count = bubble_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
`else
    assign bus.bubble_count = CNT_W'(0);
    assign bus.flush_count  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg against a behavioural model of the
// ID/EX slot (priority: reset, flush, stall, load-use bubble, load).
module tb_id_ex_stage_reg;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of what the EX stage should see
    typedef struct packed {
        logic        valid, regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [1:0]  aluOp;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm, pc4;
    } slot_t;

    slot_t       m;
    int unsigned m_bubbles;
    int unsigned m_flushes;
    int          total;
    int          bad;

    function automatic slot_t observed();
        slot_t o;
        o = '{bus.ID_EX_valid, bus.ID_EX_regWrite, bus.ID_EX_memRead,
              bus.ID_EX_memWrite, bus.ID_EX_memToReg, bus.ID_EX_aluSrc,
              bus.ID_EX_regDst, bus.ID_EX_aluOp, bus.ID_EX_rs, bus.ID_EX_rt,
              bus.ID_EX_rd, bus.ID_EX_readData1, bus.ID_EX_readData2,
              bus.ID_EX_imm, bus.ID_EX_pc4};
        return o;
    endfunction

    // A load in EX whose destination the decoding instruction reads
    function automatic logic model_hold();
        if (flush || !m.valid || !m.memRead || !bus.id_valid || m.rt == 5'd0) return 1'b0;
        return (m.rt == bus.id_rs) || (m.rt == bus.id_rt);
    endfunction

    function automatic logic [31:0] exp_bubbles();
        return PERF ? 32'(m_bubbles) : 32'h0;
    endfunction

    function automatic logic [31:0] exp_flushes();
        return PERF ? 32'(m_flushes) : 32'h0;
    endfunction

    // Advance the model over one edge using the current inputs, then clock
    task automatic tick();
        logic h;
        h = model_hold();
        if (!rst_n) begin
            m = '0; m_bubbles = 0; m_flushes = 0;
        end else if (flush) begin
            m = '0; m_flushes++;
        end else if (stall) begin
            m = m;
        end else if (h) begin
            m = '0; m_bubbles++;
        end else begin
            m.valid    = bus.id_valid;
            m.regWrite = bus.id_regWrite & bus.id_valid;
            m.memRead  = bus.id_memRead & bus.id_valid;
            m.memWrite = bus.id_memWrite & bus.id_valid;
            m.memToReg = bus.id_memToReg;
            m.aluSrc   = bus.id_aluSrc;
            m.regDst   = bus.id_regDst;
            m.aluOp    = bus.id_aluOp;
            m.rs = bus.id_rs; m.rt = bus.id_rt; m.rd = bus.id_rd;
            m.rd1 = bus.id_readData1; m.rd2 = bus.id_readData2;
            m.imm = bus.id_imm; m.pc4 = bus.id_pc4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input int reg_range);
        bus.id_valid     = 1'($urandom_range(0, 3) != 0);
        bus.id_regWrite  = 1'($urandom);
        bus.id_memRead   = 1'($urandom);
        bus.id_memWrite  = 1'($urandom);
        bus.id_memToReg  = 1'($urandom);
        bus.id_aluSrc    = 1'($urandom);
        bus.id_regDst    = 1'($urandom);
        bus.id_aluOp     = 2'($urandom);
        bus.id_rs        = 5'($urandom_range(0, reg_range));
        bus.id_rt        = 5'($urandom_range(0, reg_range));
        bus.id_rd        = 5'($urandom);
        bus.id_readData1 = $urandom;
        bus.id_readData2 = $urandom;
        bus.id_imm       = $urandom;
        bus.id_pc4       = $urandom;
    endtask

    task automatic drive_clear();
        bus.id_valid = 0; bus.id_regWrite = 0; bus.id_memRead = 0;
        bus.id_memWrite = 0; bus.id_memToReg = 0; bus.id_aluSrc = 0;
        bus.id_regDst = 0; bus.id_aluOp = 0; bus.id_rs = 0; bus.id_rt = 0;
        bus.id_rd = 0; bus.id_readData1 = 0; bus.id_readData2 = 0;
        bus.id_imm = 0; bus.id_pc4 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_random(31);
            stall = 1'($urandom);
            flush = 1'($urandom);
            tick();
        end
        total++;
        if (observed() !== slot_t'(0)) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", observed());
        end
        flush = 1'b0;
        #1;
        total++;
        if (bus.ld_use_hold !== 1'b0) begin
            bad++; $display("FAIL reset_hold got=%b want=0", bus.ld_use_hold);
        end
        total++;
        if (bus.bubble_count !== 32'h0 || bus.flush_count !== 32'h0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.bubble_count, bus.flush_count);
        end
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_clear();
    endtask

    task automatic test_normal_flow();
        drive_clear();
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 4; bus.id_rd = 5;
        bus.id_readData1 = 32'h1234; bus.id_regWrite = 1;
        tick();
        total++;
        if (bus.ID_EX_rs !== 5'd3 || bus.ID_EX_rt !== 5'd4 || bus.ID_EX_rd !== 5'd5 ||
            bus.ID_EX_readData1 !== 32'h1234 || bus.ID_EX_regWrite !== 1'b1) begin
            bad++; $display("FAIL normal_fields got rs=%0d rt=%0d rd=%0d d1=%h rw=%b want 3 4 5 1234 1",
                bus.ID_EX_rs, bus.ID_EX_rt, bus.ID_EX_rd, bus.ID_EX_readData1, bus.ID_EX_regWrite);
        end
        total++;
        if (observed() !== m) begin
            bad++; $display("FAIL normal_slot got=%h want=%h", observed(), m);
        end
        // Invalid slot: controls load but side effects are gated off
        bus.id_valid = 0; bus.id_memRead = 1; bus.id_memWrite = 1; bus.id_regWrite = 1;
        bus.id_aluSrc = 1; bus.id_rd = 9;
        tick();
        total++;
        if (bus.ID_EX_regWrite !== 1'b0 || bus.ID_EX_memRead !== 1'b0 ||
            bus.ID_EX_memWrite !== 1'b0 || bus.ID_EX_aluSrc !== 1'b1 || bus.ID_EX_rd !== 5'd9) begin
            bad++; $display("FAIL invalid_gating got rw=%b mr=%b mw=%b as=%b rd=%0d want 0 0 0 1 9",
                bus.ID_EX_regWrite, bus.ID_EX_memRead, bus.ID_EX_memWrite, bus.ID_EX_aluSrc, bus.ID_EX_rd);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] b0;
        drive_clear();
        bus.id_valid = 1; bus.id_memRead = 1; bus.id_memToReg = 1; bus.id_regWrite = 1;
        bus.id_rs = 1; bus.id_rt = 8; bus.id_aluSrc = 1;
        tick();
        b0 = exp_bubbles();
        drive_clear();
        bus.id_valid = 1; bus.id_regWrite = 1; bus.id_regDst = 1; bus.id_aluOp = 2'b10;
        bus.id_rs = 8; bus.id_rt = 2; bus.id_rd = 10;
        #1;
        total++;
        if (bus.ld_use_hold !== 1'b1) begin
            bad++; $display("FAIL lu_hold got=%b want=1", bus.ld_use_hold);
        end
        tick();
        total++;
        if (bus.ID_EX_valid !== 1'b0 || bus.ID_EX_regWrite !== 1'b0 || bus.ld_use_hold !== 1'b0) begin
            bad++; $display("FAIL lu_bubble got v=%b rw=%b hold=%b want 0 0 0",
                bus.ID_EX_valid, bus.ID_EX_regWrite, bus.ld_use_hold);
        end
        tick();
        total++;
        if (bus.ID_EX_rs !== 5'd8 || bus.ID_EX_valid !== 1'b1 || bus.ld_use_hold !== 1'b0) begin
            bad++; $display("FAIL lu_dependent got rs=%0d v=%b hold=%b want 8 1 0",
                bus.ID_EX_rs, bus.ID_EX_valid, bus.ld_use_hold);
        end
        total++;
        if (bus.bubble_count !== (PERF ? b0 + 32'd1 : 32'h0)) begin
            bad++; $display("FAIL lu_bubble_count got=%0d want=%0d", bus.bubble_count, PERF ? b0 + 32'd1 : 32'h0);
        end
    endtask

    task automatic test_zero_exempt();
        drive_clear();
        bus.id_valid = 1; bus.id_memRead = 1; bus.id_rt = 0; bus.id_rs = 2;
        tick();
        drive_clear();
        bus.id_valid = 1; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 6;
        #1;
        total++;
        if (bus.ld_use_hold !== 1'b0) begin
            bad++; $display("FAIL zero_hold got=%b want=0", bus.ld_use_hold);
        end
        tick();
        total++;
        if (bus.ID_EX_valid !== 1'b1 || bus.ID_EX_rd !== 5'd6) begin
            bad++; $display("FAIL zero_no_bubble got v=%b rd=%0d want 1 6", bus.ID_EX_valid, bus.ID_EX_rd);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] f0;
        drive_clear();
        bus.id_valid = 1; bus.id_rd = 7; bus.id_regWrite = 1;
        tick();
        drive_random(31);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.ID_EX_rd !== 5'd7 || bus.ID_EX_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold cyc=%0d got rd=%0d v=%b want 7 1", i, bus.ID_EX_rd, bus.ID_EX_valid);
            end
        end
        f0 = exp_flushes();
        flush = 1'b1;
        tick();
        total++;
        if (bus.ID_EX_valid !== 1'b0 || bus.ID_EX_regWrite !== 1'b0) begin
            bad++; $display("FAIL stall_flush_bubble got v=%b rw=%b want 0 0", bus.ID_EX_valid, bus.ID_EX_regWrite);
        end
        total++;
        if (bus.flush_count !== (PERF ? f0 + 32'd1 : 32'h0)) begin
            bad++; $display("FAIL flush_count got=%0d want=%0d", bus.flush_count, PERF ? f0 + 32'd1 : 32'h0);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_flush_hazard();
        logic [31:0] b0;
        drive_clear();
        bus.id_valid = 1; bus.id_memRead = 1; bus.id_rt = 9; bus.id_rs = 1;
        tick();
        b0 = exp_bubbles();
        drive_clear();
        bus.id_valid = 1; bus.id_rs = 9; bus.id_rt = 3;
        flush = 1'b1;
        #1;
        total++;
        if (bus.ld_use_hold !== 1'b0) begin
            bad++; $display("FAIL flush_kills_hold got=%b want=0", bus.ld_use_hold);
        end
        tick();
        total++;
        if (bus.ID_EX_valid !== 1'b0 || bus.ID_EX_memRead !== 1'b0 || bus.bubble_count !== b0) begin
            bad++; $display("FAIL flush_hazard got v=%b mr=%b bc=%0d want 0 0 %0d",
                bus.ID_EX_valid, bus.ID_EX_memRead, bus.bubble_count, b0);
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_random(3);
            rst_n = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            total++;
            if (bus.ld_use_hold !== model_hold()) begin
                bad++; $display("FAIL rnd_hold cyc=%0d got=%b want=%b", i, bus.ld_use_hold, model_hold());
            end
            tick();
            total++;
            if (observed() !== m || bus.bubble_count !== exp_bubbles() || bus.flush_count !== exp_flushes()) begin
                bad++; $display("FAIL rnd_slot cyc=%0d got=%h bc=%0d fc=%0d want=%h bc=%0d fc=%0d",
                    i, observed(), bus.bubble_count, bus.flush_count, m, exp_bubbles(), exp_flushes());
            end
        end
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        m = '0; m_bubbles = 0; m_flushes = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_clear();
        #1;
        test_reset();
        test_normal_flow();
        test_load_use();
        test_zero_exempt();
        test_stall_flush();
        test_flush_hazard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
